// File: rtl/kbd_pkg.sv
// Shared types and constants for the Apple-1 style keyboard port controller.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ACK,
    GUARD
  } kbd_state_t;

  localparam logic KBD_A   = 1'b0;
  localparam logic KBDCR_A = 1'b1;

  localparam int RDY_B = 7;
  localparam int OVF_B = 6;

endpackage

// File: rtl/kbd_port_ctrl_if.sv
// Decoder handshake and CPU read-port signals of the keyboard port controller.
interface kbd_port_ctrl_if #(
  parameter int AW = 3
);
  logic [7:0]  kbd_q;
  logic        dec_clr;
  logic        addr;
  logic        rd;
  logic [7:0]  rdata;
  logic        key_avail;
  logic [AW:0] count;

  modport master (
    output kbd_q, addr, rd,
    input  dec_clr, rdata, key_avail, count
  );

  modport slave (
    input  kbd_q, addr, rd,
    output dec_clr, rdata, key_avail, count
  );
endinterface

// File: rtl/kbd_fifo.sv
// DEPTH x 8 synchronous FIFO; a pop frees space for a push in the same cycle.
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        CLOCK_50,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kbd_port_ctrl.sv
// Captures keys from the PS/2 decoder via a flag/clear handshake and serves them
// to the CPU through KBD/KBDCR read registers backed by a FIFO.
module kbd_port_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLOCK_50,
  input  logic           clr,
  kbd_port_ctrl_if.slave bus
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   flag_s;
  kbd_state_t             state_q, state_d;
  logic                   dec_clr_q, dec_clr_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   capture, pop_req, overflow;
  logic [7:0]             fifo_dout;
  logic                   fifo_full, fifo_empty;
  logic [AW:0]            fifo_count;

  assign flag_s = sync_q[SYNC_STAGES-1];

  // NOTE: non-blocking updates so each stage samples the previous stage's pre-edge value.
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.kbd_q[7]};
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:    if (flag_s) state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = ACK;
      end
      ACK:     if (!flag_s) state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dec_clr_d = (state_d == ACK);
  assign pop_req   = bus.rd && (bus.addr == KBD_A);
  // A full FIFO still accepts the key when a KBD read frees a slot this cycle.
  assign overflow  = capture && fifo_full && !pop_req;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.rd && (bus.addr == KBDCR_A)) ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd) begin
      if (bus.addr == KBD_A) begin
        rdata_d = fifo_empty ? 8'h00 : fifo_dout;
      end else begin
        rdata_d        = 8'h00;
        rdata_d[RDY_B] = !fifo_empty;
        rdata_d[OVF_B] = ovf_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      dec_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      dec_clr_q <= dec_clr_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  kbd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .clr      (clr),
    .push     (capture),
    .pop      (pop_req),
    .din      ({1'b1, bus.kbd_q[6:0]}),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.dec_clr   = dec_clr_q;
  assign bus.rdata     = rdata_q;
  assign bus.count     = fifo_count;
  assign bus.key_avail = (fifo_count != '0);

endmodule
